// File: rtl/sid_fc_curve_if.sv
// sid_fc_curve_if: request/result and knot-table write bundle for the SID cutoff curve.
interface sid_fc_curve_if;
    logic [10:0] fc;
    logic        start;
    logic        busy;
    logic [17:0] f0_out;
    logic        f0_valid;
    logic        tbl_we;
    logic [4:0]  tbl_addr;
    logic [16:0] tbl_data;
    modport master (output fc, start, tbl_we, tbl_addr, tbl_data, input busy, f0_out, f0_valid);
    modport slave (input fc, start, tbl_we, tbl_addr, tbl_data, output busy, f0_out, f0_valid);
endinterface

// File: rtl/sid_fc_curve.sv
// sid_fc_curve: maps the 11-bit SID cutoff register to an F0 coefficient by
// piecewise-linear interpolation over a writable 17-knot table.
module sid_fc_curve (
    input logic clk,
    input logic rst,
    sid_fc_curve_if.slave bus
);
    localparam logic [2:0] IDLE = 3'd0, RDA = 3'd1, RDB = 3'd2, DIFF = 3'd3, MUL = 3'd4, SUM = 3'd5;
    logic [2:0] st;
    logic [16:0] k [0:16];
    logic [10:0] fc_l;
    logic [3:0] s;
    logic [16:0] ka, kb, kb_n;
    logic signed [17:0] diff;
    logic signed [24:0] prod, sum;
    logic [17:0] f0;
    logic vld;
    assign s = fc_l[10:7];
    assign kb_n = (s == 4'd15) ? k[16] : k[s + 4'd1];
    // Arithmetic shift floors negative slopes toward minus infinity.
    assign sum = 25'($signed({1'b0, ka})) + (prod >>> 7);
    assign bus.busy = st != IDLE;
    assign bus.f0_out = f0;
    assign bus.f0_valid = vld;
    always_ff @(posedge clk) begin
        if (rst)
            st <= IDLE;
        else
            st <= (st == IDLE) ? (bus.start ? RDA : IDLE) : ((st == SUM) ? IDLE : st + 3'd1);
    end
    always_ff @(posedge clk) begin
        if (st == IDLE && bus.start) fc_l <= bus.fc;
        if (st == RDA) ka <= k[s];
        if (st == RDB) kb <= kb_n;
        if (st == DIFF) diff <= $signed({1'b0, kb}) - $signed({1'b0, ka});
        if (st == MUL) prod <= 25'(diff) * 25'($signed({1'b0, fc_l[6:0]}));
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            f0 <= '0;
            vld <= 1'b0;
        end else begin
            vld <= st == SUM;
            if (st == SUM) f0 <= 18'(sum);
        end
    end
    always_ff @(posedge clk) begin
        for (int i = 0; i < 17; i++)
            if (rst)
                k[i] <= 17'(i * 4096);
            else if (bus.tbl_we && bus.tbl_addr == 5'(i))
                k[i] <= bus.tbl_data;
    end
endmodule

// File: tb/tb_sid_fc_curve.sv
// tb_sid_fc_curve: directed curve points plus randomized traffic, all checked
// every cycle against a cycle-counting interpolation model.
module tb_sid_fc_curve;
    logic clk = 1'b0;
    logic rst = 1'b1;
    sid_fc_curve_if bus ();
    sid_fc_curve dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;

    int total = 0, fails = 0;
    int km [17];
    int phase = 0, fc_m = 0, ka_m = 0, kb_m = 0;
    int exp_f0 = 0;
    bit exp_valid = 0;
    int cyc = 0;

    function automatic int floor128(int num);
        return (num >= 0) ? num / 128 : -((-num + 127) / 128);
    endfunction

    task automatic chk(string name, longint got, longint want);
        total++;
        if (got != want) begin
            fails++;
            $display("FAIL %s at cycle %0d: got %0d want %0d", name, cyc, got, want);
        end
    endtask

    // Model: count cycles since acceptance; knots are sampled one and two
    // edges after acceptance, before that edge's table write lands.
    initial forever begin
        @(posedge clk);
        cyc++;
        if (rst) begin
            for (int i = 0; i < 17; i++) km[i] = i * 4096;
            phase = 0;
            exp_f0 = 0;
            exp_valid = 0;
        end else begin
            exp_valid = 0;
            if (phase == 0) begin
                if (bus.start) begin fc_m = bus.fc; phase = 1; end
            end else begin
                if (phase == 1) ka_m = km[fc_m / 128];
                if (phase == 2) kb_m = km[fc_m / 128 + 1];
                if (phase == 5) begin
                    exp_f0 = ka_m + floor128((kb_m - ka_m) * (fc_m % 128));
                    exp_valid = 1;
                end
                phase = (phase == 5) ? 0 : phase + 1;
            end
            if (bus.tbl_we && bus.tbl_addr <= 16) km[bus.tbl_addr] = bus.tbl_data;
        end
    end

    initial forever begin
        @(negedge clk);
        chk("busy", bus.busy, phase != 0);
        chk("f0_valid", bus.f0_valid, exp_valid);
        chk("f0_out", bus.f0_out, exp_f0);
    end

    task automatic compute(input logic [10:0] v, input int want, input string name);
        int lat = 0;
        bus.fc = v;
        bus.start = 1;
        @(negedge clk);
        bus.start = 0;
        for (int i = 1; i <= 10 && lat == 0; i++) begin
            @(negedge clk);
            if (bus.f0_valid) lat = i;
        end
        chk({name, "_latency"}, lat, 5);
        chk({name, "_value"}, bus.f0_out, want);
    endtask

    task automatic wr(input int a, input int d);
        bus.tbl_we = 1;
        bus.tbl_addr = 5'(a);
        bus.tbl_data = 17'(d);
        @(negedge clk);
        bus.tbl_we = 0;
    endtask

    initial begin
        int pulses, last, t;
        bus.fc = 0; bus.start = 0; bus.tbl_we = 0; bus.tbl_addr = 0; bus.tbl_data = 0;
        repeat (2) @(negedge clk);
        rst = 0;
        chk("reset_busy", bus.busy, 0);
        chk("reset_f0", bus.f0_out, 0);
        chk("reset_valid", bus.f0_valid, 0);
        compute(11'h400, 32768, "mid");
        compute(11'h7FF, 65504, "top");
        wr(3, 1000);
        wr(4, 0);
        compute(11'h1C0, 500, "neg_slope");
        wr(3, 1);
        compute(11'h181, 0, "floor_neg");
        // Second start two edges later must be dropped.
        bus.fc = 11'h400; bus.start = 1;
        @(negedge clk);
        bus.start = 0;
        @(negedge clk);
        bus.fc = 11'h7FF; bus.start = 1;
        pulses = 0;
        for (int i = 2; i <= 12; i++) begin
            @(negedge clk);
            bus.start = 0;
            if (bus.f0_valid) begin pulses++; t = i; end
        end
        chk("ignore_busy_pulses", pulses, 1);
        chk("ignore_busy_at", t, 5);
        chk("ignore_busy_value", bus.f0_out, 32768);
        // Reset mid-computation aborts and restores defaults.
        bus.fc = 11'h7FF; bus.start = 1;
        @(negedge clk);
        bus.start = 0;
        repeat (2) @(negedge clk);
        rst = 1;
        @(negedge clk);
        rst = 0;
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.f0_valid) pulses++;
        end
        chk("abort_pulses", pulses, 0);
        chk("abort_busy", bus.busy, 0);
        chk("abort_f0", bus.f0_out, 0);
        compute(11'h080, 4096, "defaults");
        // Held start: accepted every six cycles.
        bus.fc = 11'h123; bus.start = 1;
        pulses = 0; last = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.f0_valid) begin
                if (last >= 0) chk("b2b_gap", i - last, 6);
                last = i;
                pulses++;
            end
        end
        bus.start = 0;
        chk("b2b_pulses_min", pulses >= 6, 1);
        repeat (8) @(negedge clk);
        for (int i = 0; i < 3000; i++) begin
            bus.start = ($urandom_range(0, 3) == 0);
            bus.fc = 11'($urandom);
            bus.tbl_we = ($urandom_range(0, 5) == 0);
            bus.tbl_addr = 5'($urandom_range(0, 31));
            bus.tbl_data = 17'($urandom);
            rst = ($urandom_range(0, 199) == 0);
            @(negedge clk);
        end
        bus.start = 0; bus.tbl_we = 0; rst = 0;
        repeat (10) @(negedge clk);
        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end
endmodule
